// File: rtl/ft_rca_pkg.sv
// Shared types and codeword definitions for the fault-tolerant serial adder.
package ft_rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Legal 3-to-4 codewords: bit0 = sum, bit1 = carry, upper bits are check bits.
    localparam logic [3:0] CODE_S0_C0   = 4'b0000;
    localparam logic [3:0] CODE_S1_C0_A = 4'b0101;
    localparam logic [3:0] CODE_S0_C1_A = 4'b0110;
    localparam logic [3:0] CODE_S1_C0_B = 4'b1001;
    localparam logic [3:0] CODE_S0_C1_B = 4'b1010;
    localparam logic [3:0] CODE_S1_C1   = 4'b1111;

    function automatic logic code_valid(input logic [3:0] code);
        return (code == CODE_S0_C0)   || (code == CODE_S1_C0_A) ||
               (code == CODE_S0_C1_A) || (code == CODE_S1_C0_B) ||
               (code == CODE_S0_C1_B) || (code == CODE_S1_C1);
    endfunction

endpackage

// File: rtl/ft_code_check.sv
// Combinational codeword checker: flags illegal codewords and splits out sum/carry.
module ft_code_check
    import ft_rca_pkg::*;
(
    input  logic [3:0] fa_code,
    output logic       valid,
    output logic       sum_bit,
    output logic       carry_bit
);

    // Membership test plus direct field extraction
    always_comb begin
        valid     = code_valid(fa_code);
        sum_bit   = fa_code[0];
        carry_bit = fa_code[1];
    end

endmodule

// File: rtl/ft_rca_serial.sv
// Bit-serial ripple-carry adder that retries a bit when the code table returns
// an illegal codeword, and aborts with an error flag once the retry budget is spent.
module ft_rca_serial
    import ft_rca_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [2:0]       fa_addr,
    input  logic [3:0]       fa_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_err,
    output logic [CNT_W-1:0] fault_cnt
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              carry_q, carry_d, cout_q, cout_d, err_q, err_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;

    logic cc_valid, cc_sum, cc_carry;

    ft_code_check u_code_check (
        .fa_code   (fa_code),
        .valid     (cc_valid),
        .sum_bit   (cc_sum),
        .carry_bit (cc_carry)
    );

    // Output decode straight from registered state
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        fa_addr   = 3'b000;
        if (state_q == RUN) begin
            fa_addr = {a_q[idx_q], b_q[idx_q], carry_q};
        end
        out_sum   = sum_q;
        out_cout  = cout_q;
        out_err   = err_q;
        fault_cnt = fcnt_q;
    end

    // Next-state: accept, per-bit evaluate/retry/abort, result handoff
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    retry_d = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cc_valid) begin
                    sum_d[idx_q] = cc_sum;
                    carry_d      = cc_carry;
                    retry_d      = '0;
                    if (retry_q != '0 && fcnt_q != '1) begin
                        fcnt_d = fcnt_q + CNT_W'(1);
                    end
                    if (idx_q == IDX_LAST) begin
                        cout_d  = cc_carry;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (retry_q < RTY_MAX) begin
                    retry_d = retry_q + RTY_W'(1);
                end else begin
                    // Abort: keep the bits already resolved, zero the rest
                    err_d  = 1'b1;
                    cout_d = 1'b0;
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (IDX_W'(i) >= idx_q) begin
                            sum_d[i] = 1'b0;
                        end
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            retry_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_ft_rca_serial.sv
// Self-checking bench for ft_rca_serial with an ideal code table and fault injection.
module tb_ft_rca_serial;

    localparam int W  = 8;
    localparam int MR = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_cin;
    logic [W-1:0]  in_a, in_b;
    logic [2:0]    fa_addr;
    logic [3:0]    fa_code;
    logic          out_valid, out_ready, out_cout, out_err;
    logic [W-1:0]  out_sum;
    logic [CW-1:0] fault_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int         cyc       = 0;
    int         inj_start = 0;
    int         inj_len   = 0;
    logic [3:0] inj_code  = 4'b0000;
    logic       alt       = 1'b0;
    logic [CW-1:0] exp_fc = '0;

    ft_rca_serial #(.WIDTH(W), .MAX_RETRY(MR), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .fa_addr(fa_addr), .fa_code(fa_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err),
        .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    // Ideal code table: counts ones in the address, picks either legal encoding
    function automatic logic [3:0] ideal_code(input logic [2:0] addr, input logic pick);
        int ones;
        ones = int'(addr[0]) + int'(addr[1]) + int'(addr[2]);
        case (ones)
            0:       return 4'b0000;
            1:       return pick ? 4'b1001 : 4'b0101;
            2:       return pick ? 4'b1010 : 4'b0110;
            default: return 4'b1111;
        endcase
    endfunction

    always @(negedge clk) alt <= 1'($urandom);

    always_comb begin
        fa_code = ideal_code(fa_addr, alt);
        if (inj_len > 0 && cyc >= inj_start && cyc < inj_start + inj_len)
            fa_code = inj_code;
    end

    function automatic logic [3:0] rand_bad_code();
        logic [3:0] c;
        do c = 4'($urandom_range(0, 15));
        while (c inside {4'b0000, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1111});
        return c;
    endfunction

    // Reference: arithmetic sum; a burst of L bad codes starting on bit s either
    // costs L extra cycles (L <= MR) or aborts after MR retries.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int s, input int l,
                         output logic [W-1:0] es, output logic ec, output logic ee,
                         output int el, output logic inc);
        logic [W:0]   full;
        logic [W-1:0] mask;
        full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        es = full[W-1:0]; ec = full[W]; ee = 1'b0; el = W; inc = 1'b0;
        if (l > 0 && l <= MR) begin
            el = W + l; inc = 1'b1;
        end else if (l > MR) begin
            mask = W'((1 << s) - 1);
            es = full[W-1:0] & mask; ec = 1'b0; ee = 1'b1; el = s + MR + 1;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int s, input int l, input logic [3:0] ic,
                          input bit hold, input string tag);
        logic [W-1:0] es;
        logic ec, ee, inc;
        int el, lat;
        model(a, b, cin, s, l, es, ec, ee, el, inc);
        if (inc && exp_fc != '1) exp_fc = exp_fc + 1'b1;
        @(negedge clk);
        out_ready = !hold;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        inj_start = s; inj_len = l; inj_code = ic; cyc = 0;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s in_ready: got %b want 1", tag, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++; cyc = lat;
        end
        inj_len = 0;
        n_tests++;
        if (lat != el) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", tag, lat, el); end
        n_tests++;
        if (out_sum !== es) begin n_fail++; $display("FAIL %s out_sum: got %h want %h", tag, out_sum, es); end
        n_tests++;
        if (out_cout !== ec) begin n_fail++; $display("FAIL %s out_cout: got %b want %b", tag, out_cout, ec); end
        n_tests++;
        if (out_err !== ee) begin n_fail++; $display("FAIL %s out_err: got %b want %b", tag, out_err, ee); end
        n_tests++;
        if (fault_cnt !== exp_fc) begin n_fail++; $display("FAIL %s fault_cnt: got %0d want %0d", tag, fault_cnt, exp_fc); end
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
                @(posedge clk); #1;
                n_tests++;
                if (out_valid !== 1'b1 || out_sum !== es || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s hold%0d: got valid=%b sum=%h rdy=%b want 1 %h 0", tag, k, out_valid, out_sum, in_ready, es);
                end
            end
            @(negedge clk);
            in_valid = 1'b0; out_ready = 1'b1;
        end
        @(posedge clk); #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== es || out_err !== ee) begin
            n_fail++;
            $display("FAIL %s release: got valid=%b rdy=%b sum=%h err=%b want 0 1 %h %b",
                     tag, out_valid, in_ready, out_sum, out_err, es, ee);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 ||
            out_err !== 1'b0 || fault_cnt !== '0 || fa_addr !== 3'b000) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b vld=%b sum=%h co=%b err=%b fc=%0d addr=%b want 1 0 00 0 0 0 000",
                     tag, in_ready, out_valid, out_sum, out_cout, out_err, fault_cnt, fa_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
        #1;
        check_reset_outputs("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_fc = '0;
    endtask

    task automatic test_directed();
        run_op(8'h5A, 8'h3C, 1'b0, 0, 0, 4'b0000, 1'b0, "add_5a_3c");
        run_op(8'hFF, 8'h01, 1'b1, 0, 0, 4'b0000, 1'b0, "add_ff_01_c1");
        run_op(8'h0F, 8'h01, 1'b0, 3, 2, 4'b0011, 1'b0, "retry_bit3");
        run_op(8'hB7, 8'h6D, 1'b1, 2, 4, 4'b0111, 1'b0, "abort_bit2");
        run_op(8'hC3, 8'h7E, 1'b0, 7, 3, 4'b1100, 1'b0, "retry_msb");
        run_op(8'h81, 8'h80, 1'b1, 7, 4, 4'b0001, 1'b0, "abort_msb");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 24; n++) begin
            int s, l;
            s = $urandom_range(0, W - 1);
            l = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, MR + 2);
            run_op(W'($urandom), W'($urandom), 1'($urandom), s, l, rand_bad_code(), 1'b0, "random");
        end
    endtask

    task automatic test_backpressure();
        run_op(8'h96, 8'h2B, 1'b1, 5, 1, 4'b1110, 1'b1, "backpressure");
    endtask

    task automatic test_mid_reset();
        bit seen;
        @(negedge clk);
        in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_fc = '0;
        check_reset_outputs("mid_reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_stale: got seen_valid=%b rdy=%b want 0 1", seen, in_ready);
        end
        run_op(8'h12, 8'h34, 1'b0, 1, 1, 4'b1000, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
